lfsr_19bit_checker: RTL and testbench

- Receive-side counterpart of the 19-bit LFSR pattern generator.
- Takes the generator's serial PRBS stream and self-synchronises by seeding its own LFSR from the first 19 received bits.
- Once locked, it predicts every following bit, counts mismatches and flags loss of lock.
- It sits beside the stop-watch/display path and supplies lock, error and period status for link and bit-error testing.

---
 rtl/lfsr_pkg.sv | 17 +
 rtl/lfsr_step.sv | 18 +
 rtl/lfsr_19bit_checker.sv | 142 ++++++++++++++
 tb/tb_lfsr_19bit_checker.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared constants for the 19-bit LFSR generator/checker pair
//
// Contents:
//   LFSR_W       LFSR register width
//   TAPS         feedback tap mask (taps 19,18,17,14; maximal length)
//   LFSR_PERIOD  sequence length 2^19-1
//   SEED, CHECK  checker state encoding
package lfsr_pkg;

    localparam int                  LFSR_W      = 19;
    localparam logic [LFSR_W-1:0]   TAPS        = 19'h72000;
    localparam int unsigned         LFSR_PERIOD = (1 << LFSR_W) - 1;

    localparam logic [0:0]          SEED        = 1'b0;
    localparam logic [0:0]          CHECK       = 1'b1;

endpackage

// File: rtl/lfsr_step.sv
// rtl/lfsr_step.sv - combinational LFSR step shared by generator and checker
//
// Ports:
//   sr       in   current LFSR register
//   fb       out  feedback bit, which is also the serial output bit
//   sr_next  out  register value after one step
module lfsr_step
    import lfsr_pkg::*;
(
    input  logic [LFSR_W-1:0] sr,
    output logic              fb,
    output logic [LFSR_W-1:0] sr_next
);

    assign fb      = ^(sr & TAPS);
    assign sr_next = {sr[LFSR_W-2:0], fb};

endmodule

// File: rtl/lfsr_19bit_checker.sv
// rtl/lfsr_19bit_checker.sv - self-synchronising PRBS checker for the 19-bit LFSR stream
//
// Optional feature macro: LFSR_CHK_LOSS_CNT_EN (adds the loss_count output)
//
// Ports:
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   sh_en       in   bit-valid strobe; stream_in is sampled only when high
//   stream_in   in   serial PRBS bit from the generator
//   locked      out  high while in CHECK
//   err_pulse   out  one-cycle pulse per mismatched checked bit
//   err_count   out  saturating mismatch count since reset
//   max_tick    out  one-cycle pulse every PERIOD_LEN checked bits
//   loss_count  out  saturating count of CHECK->SEED transitions (macro only)
//
// PERIOD_LEN defaults to the full sequence length; it is exposed so a
// shorter wrap can be exercised without simulating 2^19 bits.
module lfsr_19bit_checker
    import lfsr_pkg::*;
#(
    parameter int          ERR_THRESH = 4,
    parameter int          CNT_W      = 16,
    parameter int unsigned PERIOD_LEN = LFSR_PERIOD
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sh_en,
    input  logic             stream_in,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic             max_tick
`ifdef LFSR_CHK_LOSS_CNT_EN
    ,
    output logic [7:0]       loss_count
`endif
);

    localparam int SEED_W = $clog2(LFSR_W);
    localparam int RUN_W  = $clog2(ERR_THRESH + 1);

    logic [0:0]        state;
    logic [LFSR_W-1:0] sr;
    logic [SEED_W-1:0] seed_cnt;
    logic [RUN_W-1:0]  run_cnt;
    logic [LFSR_W-1:0] period_cnt;

    logic              pred;
    logic [LFSR_W-1:0] sr_pred;
    logic [LFSR_W-1:0] sr_seed;
    logic              mismatch;
    logic [RUN_W-1:0]  run_inc;
    logic              seed_last;
    logic              period_wrap;
    logic              lose_lock;

    lfsr_step u_step (
        .sr      (sr),
        .fb      (pred),
        .sr_next (sr_pred)
    );

    // While seeding, the received bit itself is shifted in; while checking,
    // the flywheel runs on the prediction so a corrupted bit never enters sr.
    assign sr_seed     = {sr[LFSR_W-2:0], stream_in};
    assign mismatch    = (stream_in != pred);
    assign run_inc     = run_cnt + RUN_W'(1);
    assign seed_last   = (seed_cnt == SEED_W'(LFSR_W - 1));
    assign period_wrap = (period_cnt == LFSR_W'(PERIOD_LEN - 1));
    assign lose_lock   = mismatch && (run_inc == RUN_W'(ERR_THRESH));

    assign locked = (state == CHECK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= SEED;
            sr         <= '0;
            seed_cnt   <= '0;
            run_cnt    <= '0;
            period_cnt <= '0;
            err_pulse  <= 1'b0;
            err_count  <= '0;
            max_tick   <= 1'b0;
        end else begin
            err_pulse <= 1'b0;
            max_tick  <= 1'b0;
            if (sh_en) begin
                if (state == SEED) begin
                    sr <= sr_seed;
                    if (seed_last) begin
                        // An all-zero window is the LFSR lock-up value; it
                        // cannot come from a live generator, so reseed.
                        seed_cnt <= '0;
                        if (sr_seed != '0) begin
                            state      <= CHECK;
                            period_cnt <= '0;
                            run_cnt    <= '0;
                        end
                    end else begin
                        seed_cnt <= seed_cnt + SEED_W'(1);
                    end
                end else begin
                    sr <= sr_pred;

                    if (period_wrap) begin
                        max_tick   <= 1'b1;
                        period_cnt <= '0;
                    end else begin
                        period_cnt <= period_cnt + LFSR_W'(1);
                    end

                    if (mismatch) begin
                        err_pulse <= 1'b1;
                        if (err_count != '1) begin
                            err_count <= err_count + CNT_W'(1);
                        end
                        run_cnt <= run_inc;
                    end else begin
                        run_cnt <= '0;
                    end

                    if (lose_lock) begin
                        state    <= SEED;
                        seed_cnt <= '0;
                        run_cnt  <= '0;
                    end
                end
            end
        end
    end

`ifdef LFSR_CHK_LOSS_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            loss_count <= '0;
        end else if (sh_en && (state == CHECK) && lose_lock && (loss_count != 8'hFF)) begin
            loss_count <= loss_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_lfsr_19bit_checker.sv
// tb/tb_lfsr_19bit_checker.sv - self-checking bench for lfsr_19bit_checker
module tb_lfsr_19bit_checker;

    localparam int PER = 1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sh_en = 1'b0;
    logic        stream_in = 1'b0;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_count;
    logic        max_tick;
`ifdef LFSR_CHK_LOSS_CNT_EN
    logic [7:0]  loss_count;
`endif

    int tests = 0;
    int fails = 0;

    logic [18:0] gen_sr;

    lfsr_19bit_checker #(.ERR_THRESH(4), .CNT_W(16), .PERIOD_LEN(PER)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sh_en      (sh_en),
        .stream_in  (stream_in),
        .locked     (locked),
        .err_pulse  (err_pulse),
        .err_count  (err_count),
        .max_tick   (max_tick)
`ifdef LFSR_CHK_LOSS_CNT_EN
        ,
        .loss_count (loss_count)
`endif
    );

    always #5 clk = ~clk;

    // Independent generator model: fb = parity of taps 19,18,17,14.
    task automatic gen_next(output logic b);
        logic f;
        f = gen_sr[18] ^ gen_sr[17] ^ gen_sr[16] ^ gen_sr[13];
        gen_sr = {gen_sr[17:0], f};
        b = f;
    endtask

    // Present one cycle of input, then sample just after the edge.
    task automatic clk_bit(input logic en, input logic b);
        sh_en = en;
        stream_in = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send_gen(input logic invert);
        logic b;
        gen_next(b);
        clk_bit(1'b1, b ^ invert);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sh_en = 1'b0;
        stream_in = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic lock_from_seed1();
        gen_sr = 19'h00001;
        for (int i = 1; i <= 19; i++) begin
            send_gen(1'b0);
            if (i == 18) begin
                tests++;
                if (locked !== 1'b0) begin
                    fails++;
                    $display("FAIL lock_early: locked=%0b after 18 bits, required 0", locked);
                end
            end
        end
        tests++;
        if (locked !== 1'b1) begin
            fails++;
            $display("FAIL lock_19: locked=%0b after 19 bits, required 1", locked);
        end
    endtask

    task automatic test_reset();
        int bad;
        rst_n = 1'b0;
        sh_en = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        tests++;
        if ({locked, err_pulse, max_tick} !== 3'b000 || err_count !== 16'd0) begin
            fails++;
            $display("FAIL reset_state: locked=%0b err_pulse=%0b max_tick=%0b err_count=%0d, required all 0",
                     locked, err_pulse, max_tick, err_count);
        end
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            clk_bit(1'b0, 1'($urandom_range(0, 1)));
            if ({locked, err_pulse, max_tick} !== 3'b000 || err_count !== 16'd0) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL idle: %0d idle cycles with nonzero outputs, required 0", bad);
        end
    endtask

    task automatic test_clean_lock();
        int bad;
        int n;
        logic b;
        do_reset();
        lock_from_seed1();
        bad = 0;
        for (int i = 0; i < 10000; i++) begin
            send_gen(1'b0);
            if (err_pulse !== 1'b0 || locked !== 1'b1) bad++;
        end
        tests++;
        if (bad != 0 || err_count !== 16'd0) begin
            fails++;
            $display("FAIL clean_run: bad_cycles=%0d err_count=%0d, required 0 and 0", bad, err_count);
        end

        // Alternating strobe: disabled cycles carry random noise.
        do_reset();
        gen_sr = 19'h00001;
        n = 0;
        bad = 0;
        while (n < 19) begin
            gen_next(b);
            clk_bit(1'b1, b);
            n++;
            if (n == 18) begin
                clk_bit(1'b0, 1'($urandom_range(0, 1)));
                tests++;
                if (locked !== 1'b0) begin
                    fails++;
                    $display("FAIL toggle_lock_early: locked=%0b after 18 enabled bits, required 0", locked);
                end
            end else begin
                clk_bit(1'b0, 1'($urandom_range(0, 1)));
            end
        end
        tests++;
        if (locked !== 1'b1) begin
            fails++;
            $display("FAIL toggle_lock: locked=%0b after 19 enabled bits, required 1", locked);
        end
        for (int i = 0; i < 2000; i++) begin
            send_gen(1'b0);
            if (err_pulse !== 1'b0) bad++;
            clk_bit(1'b0, 1'($urandom_range(0, 1)));
            if (err_pulse !== 1'b0 || max_tick !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0 || err_count !== 16'd0 || locked !== 1'b1) begin
            fails++;
            $display("FAIL toggle_run: bad_cycles=%0d err_count=%0d locked=%0b, required 0, 0, 1",
                     bad, err_count, locked);
        end
    endtask

    task automatic test_single_error();
        int bad;
        do_reset();
        lock_from_seed1();
        repeat (499) send_gen(1'b0);
        send_gen(1'b1);
        tests++;
        if (err_pulse !== 1'b1 || err_count !== 16'd1 || locked !== 1'b1) begin
            fails++;
            $display("FAIL single_err: err_pulse=%0b err_count=%0d locked=%0b, required 1, 1, 1",
                     err_pulse, err_count, locked);
        end
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            send_gen(1'b0);
            if (err_pulse !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0 || err_count !== 16'd1 || locked !== 1'b1) begin
            fails++;
            $display("FAIL single_after: extra_pulses=%0d err_count=%0d locked=%0b, required 0, 1, 1",
                     bad, err_count, locked);
        end
    endtask

    task automatic test_loss_relock();
        int bad;
        do_reset();
        lock_from_seed1();
        repeat (100) send_gen(1'b0);
        // Three errors, a match, three errors: the run restarts, lock holds.
        bad = 0;
        repeat (3) begin
            send_gen(1'b1);
            if (err_pulse !== 1'b1 || locked !== 1'b1) bad++;
        end
        send_gen(1'b0);
        if (err_pulse !== 1'b0 || locked !== 1'b1) bad++;
        repeat (3) begin
            send_gen(1'b1);
            if (err_pulse !== 1'b1 || locked !== 1'b1) bad++;
        end
        send_gen(1'b0);
        tests++;
        if (bad != 0 || err_count !== 16'd6 || locked !== 1'b1) begin
            fails++;
            $display("FAIL broken_runs: bad=%0d err_count=%0d locked=%0b, required 0, 6, 1",
                     bad, err_count, locked);
        end
        repeat (3) send_gen(1'b1);
        tests++;
        if (locked !== 1'b1) begin
            fails++;
            $display("FAIL loss_early: locked=%0b after 3 errors, required 1", locked);
        end
        send_gen(1'b1);
        tests++;
        if (locked !== 1'b0 || err_pulse !== 1'b1 || err_count !== 16'd10) begin
            fails++;
            $display("FAIL loss: locked=%0b err_pulse=%0b err_count=%0d, required 0, 1, 10",
                     locked, err_pulse, err_count);
        end
        bad = 0;
        for (int i = 1; i <= 19; i++) begin
            send_gen(1'b0);
            if (err_pulse !== 1'b0) bad++;
            if (i < 19 && locked !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0 || locked !== 1'b1) begin
            fails++;
            $display("FAIL relock: bad=%0d locked=%0b after 19 bits, required 0 and 1", bad, locked);
        end
        repeat (500) send_gen(1'b0);
        tests++;
        if (err_count !== 16'd10 || locked !== 1'b1) begin
            fails++;
            $display("FAIL relock_run: err_count=%0d locked=%0b, required 10 and 1", err_count, locked);
        end
`ifdef LFSR_CHK_LOSS_CNT_EN
        tests++;
        if (loss_count !== 8'd1) begin
            fails++;
            $display("FAIL loss_count: got %0d, required 1", loss_count);
        end
`endif
    endtask

    task automatic test_zero_seed();
        int bad;
        do_reset();
        bad = 0;
        repeat (19) begin
            clk_bit(1'b1, 1'b0);
            if (locked !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0 || err_count !== 16'd0) begin
            fails++;
            $display("FAIL zero_seed: locked_cycles=%0d err_count=%0d, required 0 and 0", bad, err_count);
        end
        lock_from_seed1();
        bad = 0;
        repeat (200) begin
            send_gen(1'b0);
            if (err_pulse !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0 || err_count !== 16'd0) begin
            fails++;
            $display("FAIL zero_seed_run: pulses=%0d err_count=%0d, required 0 and 0", bad, err_count);
        end
    endtask

    task automatic test_period();
        int ticks;
        int first_tick;
        int second_tick;
        do_reset();
        lock_from_seed1();
        ticks = 0;
        first_tick = -1;
        second_tick = -1;
        for (int i = 1; i <= 2 * PER; i++) begin
            send_gen(1'b0);
            if (max_tick === 1'b1) begin
                ticks++;
                if (ticks == 1) first_tick = i;
                if (ticks == 2) second_tick = i;
            end
        end
        tests++;
        if (ticks != 2 || first_tick != PER || second_tick != 2 * PER) begin
            fails++;
            $display("FAIL period_ticks: count=%0d at %0d,%0d, required 2 at %0d,%0d",
                     ticks, first_tick, second_tick, PER, 2 * PER);
        end
        // Error on the wrap bit: both pulses together.
        repeat (PER - 1) send_gen(1'b0);
        send_gen(1'b1);
        tests++;
        if (max_tick !== 1'b1 || err_pulse !== 1'b1 || err_count !== 16'd1) begin
            fails++;
            $display("FAIL wrap_err: max_tick=%0b err_pulse=%0b err_count=%0d, required 1, 1, 1",
                     max_tick, err_pulse, err_count);
        end
        // Threshold loss landing on the wrap bit still ticks.
        repeat (PER - 4) send_gen(1'b0);
        repeat (4) send_gen(1'b1);
        tests++;
        if (max_tick !== 1'b1 || locked !== 1'b0 || err_count !== 16'd5) begin
            fails++;
            $display("FAIL wrap_loss: max_tick=%0b locked=%0b err_count=%0d, required 1, 0, 5",
                     max_tick, locked, err_count);
        end
        repeat (19) send_gen(1'b0);
        repeat (50) send_gen(1'b0);
        tests++;
        if (locked !== 1'b1) begin
            fails++;
            $display("FAIL wrap_relock: locked=%0b, required 1", locked);
        end
        // Asynchronous reset between edges.
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({locked, err_pulse, max_tick} !== 3'b000 || err_count !== 16'd0) begin
            fails++;
            $display("FAIL async_reset: locked=%0b err_pulse=%0b max_tick=%0b err_count=%0d, required all 0",
                     locked, err_pulse, max_tick, err_count);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_clean_lock();
        test_single_error();
        test_loss_relock();
        test_zero_seed();
        test_period();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
